vga_timing_gen: RTL

Raster timing generator that produces the pixel coordinates, sync pulses, blanking flag and once-per-frame `frame_pulse` consumed by the scroll offset logic and the pixel renderers. It divides the system clock down to a pixel rate, walks a horizontal/vertical counter pair through a full frame including porches and sync, and signals the start of vertical blanking so per-frame state updates happen off-screen. Default timing is 640x480 @ 60 Hz from a 100 MHz clock.

---
 rtl/vga_timing_gen.sv | 69 ++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing with pixel divider, h/v counters, registered syncs and frame strobe.
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_pulse
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   logic       run;
   logic [3:0] div, div_n;
   logic [9:0] x_n, y_n;
   logic       h_wrap;
   // the divider idles one cycle after release so the first tick lands on cycle CLK_DIV
   always_comb begin
      div_n  = run ? (div == DIV_MAX ? 4'd0 : div + 4'd1) : 4'd0;
      h_wrap = pixel_x == H_MAX;
      x_n    = pixel_tick ? (h_wrap ? 10'd0 : pixel_x + 10'd1) : pixel_x;
      y_n    = (pixel_tick && h_wrap) ? (pixel_y == V_MAX ? 10'd0 : pixel_y + 10'd1) : pixel_y;
   end
   // decodes use the next counter values so they line up with the counters they describe
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         run         <= 1'b0;
         div         <= 4'd0;
         pixel_tick  <= 1'b0;
         pixel_x     <= 10'd0;
         pixel_y     <= 10'd0;
         video_on    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_pulse <= 1'b0;
      end else begin
         run         <= 1'b1;
         div         <= div_n;
         pixel_tick  <= div_n == DIV_MAX;
         pixel_x     <= x_n;
         pixel_y     <= y_n;
         video_on    <= x_n < H_ACT && y_n < V_ACT;
         hsync       <= !(x_n >= HS_BEG && x_n < HS_END);
         vsync       <= !(y_n >= VS_BEG && y_n < VS_END);
         frame_pulse <= pixel_tick && h_wrap && y_n == V_ACT;
      end
   end
endmodule
